gpk_carry_tree: RTL and testbench



---
 rtl/gpk_pkg.sv | 37 +++
 rtl/gpk_prefix_level.sv | 98 +++++++++
 rtl/gpk_carry_tree.sv | 107 ++++++++++
 tb/tb_gpk_carry_tree.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpk_pkg.sv
// Shared types and helpers for the generate/propagate/kill carry tree.
// Pure package: no logic of its own, no latency.
// Carries no flow control.
package gpk_pkg;

    // One bit's classification from the gpk cell row.
    typedef struct packed {
        logic g;
        logic p;
        logic k;
    } gpk_t;

    // Group generate/propagate pair flowing through the prefix network.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: hi is the more significant span, lo the less significant one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // True when exactly one of g, p, k is set.
    function automatic logic onehot3(input gpk_t t);
        return (t.g & ~t.p & ~t.k) | (~t.g & t.p & ~t.k) | (~t.g & ~t.p & t.k);
    endfunction

    // Number of Kogge-Stone levels for a power-of-two width.
    function automatic int prefix_levels(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/gpk_prefix_level.sv
// One Kogge-Stone level (distance D) with an optional stage register carrying valid and sideband.
// Latency: 1 cycle when PIPE=1, 0 cycles when PIPE=0.
// Backpressure: the register loads only while advance is high and holds otherwise.
module gpk_prefix_level
    import gpk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int D     = 1,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_rawp,
    input  logic             in_cin,
    input  logic             in_err,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_rawp,
    output logic             out_cin,
    output logic             out_err
);

    typedef struct packed {
        logic             vld;
        logic             err;
        logic             cin;
        logic [WIDTH-1:0] rawp;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } stage_t;

    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    stage_t           stage_nxt;
    stage_t           stage_out;

    // Combine each bit with the span D positions below it; low bits pass through.
    always_comb begin
        g_nxt = in_g;
        p_nxt = in_p;
        for (int i = D; i < WIDTH; i++) begin
            {g_nxt[i], p_nxt[i]} = gp_combine(gp_t'{g: in_g[i], p: in_p[i]},
                                              gp_t'{g: in_g[i-D], p: in_p[i-D]});
        end
    end

    // Bundle the level result with the sideband that rides along to the sum stage.
    always_comb begin
        stage_nxt      = '0;
        stage_nxt.vld  = in_vld;
        stage_nxt.err  = in_err;
        stage_nxt.cin  = in_cin;
        stage_nxt.rawp = in_rawp;
        stage_nxt.p    = p_nxt;
        stage_nxt.g    = g_nxt;
    end

    if (PIPE != 0) begin : g_reg
        stage_t stage_d;
        stage_t stage_q;

        // Shift in the new level result on advance; otherwise hold (bubbles shift too).
        always_comb begin
            stage_d = stage_q;
            if (advance) begin
                stage_d = stage_nxt;
            end
        end

        // Stage register; reset clears valid and data alike.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign stage_out = stage_q;
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = ^{clk, rst, advance};
        assign stage_out = stage_nxt;
    end

    assign out_vld  = stage_out.vld;
    assign out_err  = stage_out.err;
    assign out_cin  = stage_out.cin;
    assign out_rawp = stage_out.rawp;
    assign out_p    = stage_out.p;
    assign out_g    = stage_out.g;

endmodule

// File: rtl/gpk_carry_tree.sv
// Resolves carries from per-bit g/p/k triples via a Kogge-Stone prefix tree, then forms sum and cout.
// Latency: log2(WIDTH) cycles with PIPE=1, combinational with PIPE=0.
// Backpressure: whole pipe stalls when the output is valid and not taken; in_ready mirrors that.
module gpk_carry_tree
    import gpk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] k,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH:0]   carry,
    output logic             cout,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int L = prefix_levels(WIDTH);

    logic [WIDTH-1:0] seed_g;
    logic             seed_err;
    logic             advance;

    // Level-0 seed: fold cin into bit 0 so every carry is a pure group generate.
    always_comb begin
        seed_g    = g;
        seed_g[0] = g[0] | (p[0] & cin);
    end

    // Flag the vector if any bit is not exactly one of g/p/k; k feeds nothing else.
    always_comb begin
        seed_err = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            seed_err = seed_err | ~onehot3(gpk_t'{g: g[i], p: p[i], k: k[i]});
        end
    end

    // All stages move in lockstep; a combinational tree simply follows downstream ready.
    assign advance  = (PIPE != 0) ? (~out_valid | out_ready) : out_ready;
    assign in_ready = advance;

    for (genvar j = 0; j < L; j++) begin : g_lvl
        logic [WIDTH-1:0] i_g, i_p, i_rawp;
        logic             i_cin, i_err, i_vld;
        logic [WIDTH-1:0] o_g, o_p, o_rawp;
        logic             o_cin, o_err, o_vld;

        if (j == 0) begin : g_first
            assign i_g    = seed_g;
            assign i_p    = p;
            assign i_rawp = p;
            assign i_cin  = cin;
            assign i_err  = seed_err;
            assign i_vld  = in_valid;
        end else begin : g_next
            assign i_g    = g_lvl[j-1].o_g;
            assign i_p    = g_lvl[j-1].o_p;
            assign i_rawp = g_lvl[j-1].o_rawp;
            assign i_cin  = g_lvl[j-1].o_cin;
            assign i_err  = g_lvl[j-1].o_err;
            assign i_vld  = g_lvl[j-1].o_vld;
        end

        gpk_prefix_level #(
            .WIDTH (WIDTH),
            .D     (1 << j),
            .PIPE  (PIPE)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .in_vld   (i_vld),
            .in_g     (i_g),
            .in_p     (i_p),
            .in_rawp  (i_rawp),
            .in_cin   (i_cin),
            .in_err   (i_err),
            .out_vld  (o_vld),
            .out_g    (o_g),
            .out_p    (o_p),
            .out_rawp (o_rawp),
            .out_cin  (o_cin),
            .out_err  (o_err)
        );
    end

    // Sum stage: carries straight from the last level, sum from the raw propagate bits.
    always_comb begin
        carry     = {g_lvl[L-1].o_g, g_lvl[L-1].o_cin};
        sum       = g_lvl[L-1].o_rawp ^ carry[WIDTH-1:0];
        cout      = carry[WIDTH];
        err       = g_lvl[L-1].o_err;
        out_valid = g_lvl[L-1].o_vld;
    end

    logic unused_ok;
    assign unused_ok = ^g_lvl[L-1].o_p;

endmodule

// File: tb/tb_gpk_carry_tree.sv
module tb_gpk_carry_tree;

    localparam int W  = 8;
    localparam int LV = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] g, p, k;
    logic         cin, in_valid, out_ready;
    logic         in_ready, cout, err, out_valid;
    logic [W-1:0] sum;
    logic [W:0]   carry;

    logic [W-1:0] cg, cp, ck;
    logic         ccin, c_in_valid, c_out_ready;
    logic         c_in_ready, c_cout, c_err, c_out_valid;
    logic [W-1:0] c_sum;
    logic [W:0]   c_carry;

    gpk_carry_tree #(.WIDTH(W), .PIPE(1)) u_dut (
        .clk(clk), .rst(rst), .g(g), .p(p), .k(k), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry(carry),
        .cout(cout), .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    gpk_carry_tree #(.WIDTH(W), .PIPE(0)) u_comb (
        .clk(clk), .rst(rst), .g(cg), .p(cp), .k(ck), .cin(ccin),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .sum(c_sum), .carry(c_carry),
        .cout(c_cout), .err(c_err), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic [W:0]   carry;
        logic         err;
        int           acc_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain addition when each bit is a legal g/p split, else the carry recurrence.
    function automatic void model(input logic [W-1:0] mg, input logic [W-1:0] mp,
                                  input logic [W-1:0] mk, input logic mcin,
                                  output logic [W-1:0] s, output logic [W:0] c, output logic e);
        logic [W:0] full;
        e = 1'b0;
        for (int i = 0; i < W; i++)
            if (int'(mg[i]) + int'(mp[i]) + int'(mk[i]) != 1) e = 1'b1;
        if ((mg & mp) == '0) begin
            full = {1'b0, mg | mp} + {1'b0, mg} + {{W{1'b0}}, mcin};
            s    = full[W-1:0];
            c    = {full[W], mp ^ full[W-1:0]};
        end else begin
            c[0] = mcin;
            for (int i = 0; i < W; i++) c[i+1] = mg[i] | (mp[i] & c[i]);
            s = mp ^ c[W-1:0];
        end
    endfunction

    // Present one vector, wait for acceptance, record the expected response.
    task automatic send(input logic [W-1:0] sg, input logic [W-1:0] sp, input logic [W-1:0] sk,
                        input logic scin, input bit lat, input bit use_exp,
                        input logic [W-1:0] es, input logic [W:0] ec, input logic ee);
        exp_t e;
        bit   done = 0;
        g = sg; p = sp; k = sk; cin = scin; in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                if (use_exp) begin
                    e.sum = es; e.carry = ec; e.err = ee;
                end else begin
                    model(sg, sp, sk, scin, e.sum, e.carry, e.err);
                end
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand(input bit legal);
        logic [W-1:0] a, b, rg, rp, rk;
        int           bi;
        a  = W'($urandom);
        b  = W'($urandom);
        rg = a & b;
        rp = a ^ b;
        rk = ~(a | b);
        if (!legal) begin
            bi = $urandom_range(W - 1);
            if ($urandom_range(1) == 1) rg[bi] = ~rg[bi];
            else rk[bi] = ~rk[bi];
        end
        send(rg, rp, rk, 1'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compare every transfer against the scoreboard and check hold during stalls.
    logic         prev_stall = 1'b0;
    logic [W-1:0] hold_sum;
    logic [W:0]   hold_carry;
    logic         hold_err;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall && out_valid) begin
                    check("hold_sum", 32'(sum), 32'(hold_sum));
                    check("hold_carry", 32'(carry), 32'(hold_carry));
                    check("hold_err", 32'(err), 32'(hold_err));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", 32'(sum), 32'(e.sum));
                        check("carry", 32'(carry), 32'(e.carry));
                        check("cout", 32'(cout), 32'(e.carry[W]));
                        check("err", 32'(err), 32'(e.err));
                        if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(LV));
                    end
                end
                prev_stall = out_valid & ~out_ready;
                hold_sum   = sum;
                hold_carry = carry;
                hold_err   = err;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic comb_case(input logic [W-1:0] sg, input logic [W-1:0] sp, input logic [W-1:0] sk,
                             input logic scin, input logic [W-1:0] es, input logic [W:0] ec);
        cg = sg; cp = sp; ck = sk; ccin = scin;
        c_in_valid = 1'b1;
        c_out_ready = 1'($urandom);
        #1;
        check("comb_sum", 32'(c_sum), 32'(es));
        check("comb_carry", 32'(c_carry), 32'(ec));
        check("comb_cout", 32'(c_cout), 32'(ec[W]));
        check("comb_err", 32'(c_err), 32'd0);
        check("comb_out_valid", 32'(c_out_valid), 32'd1);
        check("comb_in_ready", 32'(c_in_ready), 32'(c_out_ready));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        g = '0; p = '0; k = '0; cin = 1'b0;
        cg = '0; cp = '0; ck = '0; ccin = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Directed: ripple, all-kill with cin, full propagate (isolated, latency checked).
        send(8'h01, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 9'h1FE, 1'b0);
        drain();
        send(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 9'h001, 1'b0);
        drain();
        send(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 9'h1FF, 1'b0);
        drain();

        // Non-one-hot bit 3 between two legal neighbours.
        send(8'h10, 8'h05, 8'hEA, 1'b0, 1'b0, 1'b1, 8'h25, 9'h020, 1'b0);
        send(8'h08, 8'h08, 8'hF7, 1'b0, 1'b0, 1'b1, 8'h18, 9'h010, 1'b1);
        send(8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 8'h0F, 9'h000, 1'b0);
        drain();

        // Backpressure: six back-to-back vectors, out_ready low for three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand(1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'(out_ready));
                end
            end
        join
        drain();

        // Random traffic with random downstream stalls and occasional illegal vectors.
        fork
            begin
                for (int i = 0; i < 60; i++) send_rand($urandom_range(4) != 0);
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with vectors in flight: everything in the pipe is discarded.
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        // Combinational variant: same directed vectors, results with zero latency.
        comb_case(8'h01, 8'hFE, 8'h00, 1'b0, 8'h00, 9'h1FE);
        comb_case(8'h00, 8'h00, 8'hFF, 1'b1, 8'h01, 9'h001);
        comb_case(8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, 9'h1FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
